click_decoder: RTL and testbench

- Front-end stage for the De0 Nano SDRAM test harness. Sits directly upstream of the button/dip interface that issues SDRAM read and write requests.
- Synchronises and debounces the raw push-button, then classifies each gesture as a single click or a double click.
- Presents one classified event at a time on a valid/ack handshake. Single click selects write; double click selects read.

---
 rtl/click_decoder.sv | 156 +++++++++++++++
 tb/tb_click_decoder.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : click_decoder
// Description : Synchronises and debounces a raw active-low push-button, then
//               classifies each press gesture as a single or a double click.
//               Classified events are offered one at a time on a valid/ack
//               handshake. Single click selects write, double click selects
//               read in the downstream SDRAM test harness.
// Ports       : clk         - system clock (only clock)
//               rst         - synchronous reset, active-high
//               btn_n       - raw push-button, active-low, asynchronous, bouncy
//               btn_level   - debounced button level, 1 = pressed
//               evt_valid   - classified click event pending
//               evt_double  - event type while evt_valid: 0 single, 1 double
//               evt_ack     - consumer accepts the pending event
//               evt_overrun - sticky: an event was dropped while one pending
// Revision    : 1.0 - initial release
// ============================================================================
module click_decoder #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int WINDOW_CYCLES   = 12500000,
  parameter int CNT_WIDTH       = 24
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_n,
  input  logic evt_ack,
  output logic btn_level,
  output logic evt_valid,
  output logic evt_double,
  output logic evt_overrun
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] WIN_LAST = CNT_WIDTH'(WINDOW_CYCLES - 1);

  logic                 sync_q1;
  logic                 sync_q2;
  logic                 btn_sync;
  logic [CNT_WIDTH-1:0] db_cnt;
  logic                 level_d;
  logic                 press;
  logic [0:0]           state;
  logic [CNT_WIDTH-1:0] win_cnt;
  logic                 emit;
  logic                 emit_double;

  // Two-flop synchroniser; reset value is the released (high) level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q1 <= 1'b1;
      sync_q2 <= 1'b1;
    end else begin
      sync_q1 <= btn_n;
      sync_q2 <= sync_q1;
    end
  end

  assign btn_sync = ~sync_q2;

  // Debounce: the level only follows btn_sync after it has disagreed for
  // DEBOUNCE_CYCLES consecutive cycles; any agreement restarts the count.
  always_ff @(posedge clk) begin
    if (rst) begin
      btn_level <= 1'b0;
      db_cnt    <= '0;
    end else if (btn_sync == btn_level) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      btn_level <= ~btn_level;
      db_cnt    <= '0;
    end else begin
      db_cnt <= db_cnt + 1'b1;
    end
  end

  // Rising-edge detect of the debounced level; releases are not classified.
  always_ff @(posedge clk) begin
    if (rst) begin
      level_d <= 1'b0;
    end else begin
      level_d <= btn_level;
    end
  end

  assign press = btn_level & ~level_d;

  // A press arriving in the same cycle as the window timeout wins and is
  // reported as a double click.
  always_comb begin
    emit        = 1'b0;
    emit_double = 1'b0;
    if (state == ST_WAIT) begin
      if (press) begin
        emit        = 1'b1;
        emit_double = 1'b1;
      end else if (win_cnt == WIN_LAST) begin
        emit = 1'b1;
      end
    end
  end

  // Gesture FSM: IDLE waits for the first press, WAIT times the window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= ST_IDLE;
      win_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          win_cnt <= '0;
          if (press) begin
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (emit) begin
            state   <= ST_IDLE;
            win_cnt <= '0;
          end else begin
            win_cnt <= win_cnt + 1'b1;
          end
        end
        default: begin
          state   <= ST_IDLE;
          win_cnt <= '0;
        end
      endcase
    end
  end

  // Event handshake: a new event may replace the pending one only when the
  // consumer acknowledges in the same cycle; otherwise it is dropped and the
  // sticky overrun flag records the loss.
  always_ff @(posedge clk) begin
    if (rst) begin
      evt_valid   <= 1'b0;
      evt_double  <= 1'b0;
      evt_overrun <= 1'b0;
    end else if (emit) begin
      if (!evt_valid || evt_ack) begin
        evt_valid  <= 1'b1;
        evt_double <= emit_double;
      end else begin
        evt_overrun <= 1'b1;
      end
    end else if (evt_valid && evt_ack) begin
      evt_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_click_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_click_decoder
// Description : Self-checking bench for click_decoder. A timestamp-based
//               behavioural model predicts btn_level and the event handshake
//               every cycle; directed scenarios add fixed latency checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_click_decoder;

  localparam int DEB = 4;
  localparam int WIN = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_n = 1'b1;
  logic evt_ack = 1'b0;
  logic btn_level;
  logic evt_valid;
  logic evt_double;
  logic evt_overrun;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  click_decoder #(
    .DEBOUNCE_CYCLES(DEB),
    .WINDOW_CYCLES  (WIN),
    .CNT_WIDTH      (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_n      (btn_n),
    .btn_level  (btn_level),
    .evt_valid  (evt_valid),
    .evt_double (evt_double),
    .evt_ack    (evt_ack),
    .evt_overrun(evt_overrun)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Debounced level flips when the last DEB synchronised samples all
  // disagree with it. Press classification works on absolute edge numbers:
  // a second rise no later than first+WIN is a double (reported the edge
  // after that rise), otherwise a single is reported at edge first+WIN+1.
  int   cyc = 0;
  logic m_s1 = 1'b1, m_s2 = 1'b1;
  logic sync_hist[$];
  logic m_level = 1'b0;
  bit   rise_prev = 1'b0;
  bit   pend = 1'b0;
  int   first_edge = 0;
  logic m_valid = 1'b0, m_double = 1'b0, m_over = 1'b0;

  always @(posedge clk) begin : model
    bit emit;
    bit etype;
    bit all_diff;
    logic s;
    cyc++;
    if (rst) begin
      m_s1 = 1'b1; m_s2 = 1'b1;
      sync_hist.delete();
      m_level = 1'b0; rise_prev = 1'b0; pend = 1'b0;
      m_valid = 1'b0; m_double = 1'b0; m_over = 1'b0;
    end else begin
      s    = ~m_s2;
      m_s2 = m_s1;
      m_s1 = btn_n;
      emit = 1'b0; etype = 1'b0;
      if (pend) begin
        if (rise_prev) begin
          emit = 1'b1; etype = 1'b1; pend = 1'b0;
        end else if (cyc == first_edge + WIN + 1) begin
          emit = 1'b1; pend = 1'b0;
        end
      end else if (rise_prev) begin
        pend = 1'b1;
        first_edge = cyc - 1;
      end
      sync_hist.push_back(s);
      if (sync_hist.size() > DEB) void'(sync_hist.pop_front());
      rise_prev = 1'b0;
      all_diff = (sync_hist.size() == DEB);
      foreach (sync_hist[i]) if (sync_hist[i] == m_level) all_diff = 1'b0;
      if (all_diff) begin
        m_level   = ~m_level;
        rise_prev = m_level;
      end
      if (emit) begin
        if (!m_valid || evt_ack) begin
          m_valid = 1'b1; m_double = etype;
        end else begin
          m_over = 1'b1;
        end
      end else if (m_valid && evt_ack) begin
        m_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("btn_level",   btn_level,   m_level);
      check("evt_valid",   evt_valid,   m_valid);
      check("evt_double",  evt_double,  m_double);
      check("evt_overrun", evt_overrun, m_over);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Count negedges until the chosen output is 1 (0: btn_level, 1: evt_valid);
  // -1 when the bound expires.
  task automatic wait_high(input int which, input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge clk);
      n++;
      if ((which == 0) ? btn_level : evt_valid) return;
    end
    n = -1;
  endtask

  task automatic go_idle();
    btn_n = 1'b1; evt_ack = 1'b0;
    cycles(30);
    evt_ack = 1'b1; cycles(1);
    evt_ack = 1'b0; cycles(1);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; cycles(1);
    rst = 1'b0;
  endtask

  initial begin : timeout
    #1ms;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stim
    int n;
    cycles(3);
    rst = 1'b0;
    chk_en = 1'b1;
    check("reset_level",   btn_level,   0);
    check("reset_valid",   evt_valid,   0);
    check("reset_double",  evt_double,  0);
    check("reset_overrun", evt_overrun, 0);
    cycles(5);

    // Clean single press.
    btn_n = 1'b0;
    wait_high(0, 30, n);  check("press_latency", n, DEB + 2);
    wait_high(1, 40, n);  check("single_latency", n, WIN + 1);
    check("single_type", evt_double, 0);
    cycles(3);
    check("single_hold", evt_valid, 1);
    btn_n = 1'b1;
    evt_ack = 1'b1; cycles(1);
    evt_ack = 1'b0;
    check("ack_clear", evt_valid, 0);
    go_idle();

    // Bounce rejection.
    btn_n = 1'b0; cycles(3);
    btn_n = 1'b1; cycles(2);
    btn_n = 1'b0; cycles(3);
    btn_n = 1'b1; cycles(15);
    check("bounce_level", btn_level, 0);
    check("bounce_valid", evt_valid, 0);
    check("bounce_overrun", evt_overrun, 0);
    go_idle();

    // Double click: rises 10 cycles apart.
    btn_n = 1'b0; cycles(4);
    btn_n = 1'b1; cycles(6);
    btn_n = 1'b0;
    wait_high(1, 30, n);  check("double_latency", n, DEB + 3);
    check("double_type", evt_double, 1);
    evt_ack = 1'b1; cycles(1);
    evt_ack = 1'b0;
    btn_n = 1'b1; cycles(40);
    check("double_no_more", evt_valid, 0);
    go_idle();

    // Window boundary: second rise 21 cycles after the first.
    btn_n = 1'b0; cycles(4);
    btn_n = 1'b1; cycles(17);
    btn_n = 1'b0;
    wait_high(1, 30, n);  check("win_first", n, DEB + 2);
    check("win_first_type", evt_double, 0);
    evt_ack = 1'b1; cycles(1);
    evt_ack = 1'b0;
    wait_high(1, 40, n);  check("win_second", n, WIN);
    check("win_second_type", evt_double, 0);
    go_idle();

    // Overrun: two singles, never acknowledged.
    repeat (2) begin
      btn_n = 1'b0; cycles(4);
      btn_n = 1'b1; cycles(40);
    end
    check("ovr_valid", evt_valid, 1);
    check("ovr_type", evt_double, 0);
    check("ovr_flag", evt_overrun, 1);

    // Replace: ack exactly when a double is emitted over a pending single.
    pulse_rst();
    cycles(5);
    btn_n = 1'b0; cycles(4);
    btn_n = 1'b1;
    wait_high(1, 40, n);  check("repl_single_seen", n > 0, 1);
    cycles(5);
    btn_n = 1'b0; cycles(4);
    btn_n = 1'b1; cycles(6);
    btn_n = 1'b0; cycles(6);
    evt_ack = 1'b1; cycles(1);
    evt_ack = 1'b0;
    check("repl_valid", evt_valid, 1);
    check("repl_type", evt_double, 1);
    check("repl_overrun", evt_overrun, 0);
    go_idle();

    // Reset mid-gesture with the button still held.
    btn_n = 1'b0;
    wait_high(0, 30, n);  check("mid_press", n, DEB + 2);
    cycles(5);
    pulse_rst();
    check("mid_rst_level", btn_level, 0);
    check("mid_rst_valid", evt_valid, 0);
    wait_high(0, 30, n);  check("mid_level_seen", n > 0, 1);
    wait_high(1, 40, n);  check("mid_single", n, WIN + 1);
    go_idle();

    // Randomised gestures, bounces, acks and occasional resets.
    for (int g = 0; g < 150; g++) begin
      if ($urandom_range(0, 19) == 0) begin
        pulse_rst();
      end else begin
        btn_n = ~btn_n;
        repeat ($urandom_range(1, 30)) begin
          evt_ack = ($urandom_range(0, 3) == 0);
          @(negedge clk);
        end
      end
    end
    go_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
